// File: rtl/lms_pkg.sv
// lms_pkg: state encoding and parameter defaults shared by the LMS core files
package lms_pkg;
    localparam int LMS_DW      = 16;
    localparam int LMS_FRAC    = 15;
    localparam int LMS_NCH     = 4;
    localparam int LMS_TIMEOUT = 255;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;
endpackage

// File: rtl/lms_round_sat.sv
// lms_round_sat: round-half-up arithmetic shift by FRAC, then saturate (SAT=1) or wrap to DW bits
module lms_round_sat #(
    parameter int IW   = 33,
    parameter int DW   = 16,
    parameter int FRAC = 15,
    parameter int SAT  = 1
) (
    input  logic signed [IW-1:0] prod,
    output logic        [DW-1:0] r
);
    localparam logic signed [IW:0] HALF = {{IW{1'b0}}, 1'b1} << (FRAC - 1);
    logic signed [IW:0] s;
    logic [IW-DW+1:0] hi;
    logic ovf;
    assign s   = ($signed({prod[IW-1], prod}) + HALF) >>> FRAC;
    assign hi  = s[IW:DW-1];
    // Overflow when the bits above the DW-bit sign position are not a pure sign extension
    assign ovf = !((&hi) || !(|hi));
    assign r   = (SAT != 0 && ovf) ? (s[IW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                                   : s[DW-1:0];
endmodule

// File: rtl/lms_core_mc.sv
// lms_core_mc: multichannel LMS weight-update sequencer with FIR start/done handshake and timeout
module lms_core_mc
    import lms_pkg::*;
#(
    parameter int DW      = LMS_DW,
    parameter int FRAC    = LMS_FRAC,
    parameter int NCH     = LMS_NCH,
    parameter int TIMEOUT = LMS_TIMEOUT,
    parameter int SAT     = 1,
    localparam int CHW    = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [DW-1:0]  error_in,
    input  logic [DW-1:0]  desired_in,
    input  logic [DW-1:0]  feedforward_in,
    input  logic [DW-1:0]  u_in,
    input  logic [NCH-1:0] ch_enable,
    output logic           fir_go,
    output logic [CHW-1:0] fir_ch,
    output logic [DW-1:0]  feedforward_out,
    input  logic           fir_done,
    output logic [DW-1:0]  weight_adjust,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic           timeout_err,
    output logic           busy
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_d;
    logic [DW-1:0] e_r, d_r, u_r, w_next;
    logic [TW-1:0] cnt;
    logic signed [DW:0] diff;
    logic signed [2*DW:0] prod;
    logic ch_ok, go, tmo;

    assign in_ready  = state == IDLE && !rst;
    assign ch_ok     = int'(in_ch) < NCH && ch_enable[in_ch];
    assign go        = in_valid && in_ready && ch_ok;
    assign tmo       = cnt == TW'(TIMEOUT);
    assign fir_go    = state == ISSUE;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign out_ch    = fir_ch;
    assign diff      = $signed({e_r[DW-1], e_r}) - $signed({d_r[DW-1], d_r});
    assign prod      = (2*DW+1)'(diff) * (2*DW+1)'($signed(u_r));

    lms_round_sat #(.IW(2*DW+1), .DW(DW), .FRAC(FRAC), .SAT(SAT)) u_round_sat (
        .prod(prod),
        .r   (w_next)
    );

    always_ff @(posedge clk) state <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = go ? ISSUE : IDLE;
            ISSUE: state_d = WAIT;
            WAIT:  state_d = (fir_done || tmo) ? OUT : WAIT;
            OUT:   state_d = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fir_ch          <= '0;
            feedforward_out <= '0;
            weight_adjust   <= '0;
            timeout_err     <= 1'b0;
            cnt             <= '0;
            e_r             <= '0;
            d_r             <= '0;
            u_r             <= '0;
        end else begin
            if (go) begin
                fir_ch          <= in_ch;
                feedforward_out <= feedforward_in;
                e_r             <= error_in;
                d_r             <= desired_in;
                u_r             <= u_in;
            end
            if (state == ISSUE) begin
                weight_adjust <= w_next;
                cnt           <= '0;
            end
            // fir_done takes priority over an expiring counter
            if (state == WAIT && !fir_done) begin
                if (tmo) begin
                    timeout_err   <= 1'b1;
                    weight_adjust <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lms_core_mc.sv
// tb_lms_core_mc: directed and randomized transactions checked against an arithmetic model of the LMS update
module tb_lms_core_mc;
    localparam int DW = 16, FRAC = 15, NCH = 4, TIMEOUT = 8, CHW = 2;

    logic clk = 0, rst = 1, in_valid = 0, fir_done = 0, out_ready = 0;
    logic in_ready, fir_go, out_valid, timeout_err, busy;
    logic [CHW-1:0] in_ch = '0, fir_ch, out_ch;
    logic [DW-1:0] error_in = '0, desired_in = '0, feedforward_in = '0, u_in = '0;
    logic [DW-1:0] feedforward_out, weight_adjust;
    logic [NCH-1:0] ch_enable = '0;
    int vec = 0, miss = 0;
    bit te_exp = 0;

    always #5 clk = ~clk;

    lms_core_mc #(.DW(DW), .FRAC(FRAC), .NCH(NCH), .TIMEOUT(TIMEOUT), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .error_in(error_in), .desired_in(desired_in), .feedforward_in(feedforward_in),
        .u_in(u_in), .ch_enable(ch_enable), .fir_go(fir_go), .fir_ch(fir_ch),
        .feedforward_out(feedforward_out), .fir_done(fir_done), .weight_adjust(weight_adjust),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .timeout_err(timeout_err), .busy(busy)
    );

    function automatic logic [DW-1:0] ref_w(input logic signed [DW-1:0] e, d, u);
        longint p, r;
        p = (longint'(e) - longint'(d)) * longint'(u);
        r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return DW'(r);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE back to IDLE; dly = WAIT cycle in which fir_done rises
    task automatic txn(input int ch, input logic [DW-1:0] e, d, u, ff, input int dly, input int hold,
                       input logic [NCH-1:0] en);
        logic [DW-1:0] w_exp;
        int n;
        bit to, extra_go;
        to = dly > TIMEOUT;
        te_exp |= to;
        w_exp = to ? '0 : ref_w(e, d, u);
        vec++;
        if (in_ready !== 1'b1) begin
            miss++;
            $display("FAIL idle_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1; in_ch = CHW'(ch); error_in = e; desired_in = d; u_in = u; feedforward_in = ff;
        ch_enable = en | (4'b1 << ch);
        out_ready = 1'($urandom);
        step;
        in_valid = 1'($urandom); error_in = 16'($urandom); desired_in = 16'($urandom);
        u_in = 16'($urandom); feedforward_in = 16'($urandom); in_ch = 2'($urandom);
        ch_enable = 4'($urandom); fir_done = 1'($urandom);
        vec++;
        if (fir_go !== 1'b1 || fir_ch !== CHW'(ch) || feedforward_out !== ff || in_ready !== 1'b0 || busy !== 1'b1) begin
            miss++;
            $display("FAIL issue: fir_go=%b fir_ch=%0d ff=%h in_ready=%b busy=%b expected 1 %0d %h 0 1",
                     fir_go, fir_ch, feedforward_out, in_ready, busy, ch, ff);
        end
        step;
        n = 0;
        extra_go = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            fir_done = n == dly;
            out_ready = 1'($urandom);
            extra_go |= fir_go;
            step;
            n++;
        end
        fir_done = 0;
        vec++;
        if (n != (to ? TIMEOUT : dly) + 1 || extra_go) begin
            miss++;
            $display("FAIL wait_len: wait cycles=%0d extra fir_go=%b expected %0d 0",
                     n, extra_go, (to ? TIMEOUT : dly) + 1);
        end
        for (int k = 0; k <= hold; k++) begin
            out_ready = k == hold;
            vec++;
            if (out_valid !== 1'b1 || weight_adjust !== w_exp || out_ch !== CHW'(ch) ||
                timeout_err !== te_exp || in_ready !== 1'b0) begin
                miss++;
                $display("FAIL out[%0d]: valid=%b w=%h ch=%0d te=%b rdy=%b expected 1 %h %0d %b 0",
                         k, out_valid, weight_adjust, out_ch, timeout_err, in_ready, w_exp, ch, te_exp);
            end
            step;
        end
        out_ready = 1'($urandom);
        in_valid = 0;
        vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || fir_ch !== CHW'(ch) || feedforward_out !== ff) begin
            miss++;
            $display("FAIL release: valid=%b busy=%b rdy=%b fir_ch=%0d ff=%h expected 0 0 1 %0d %h",
                     out_valid, busy, in_ready, fir_ch, feedforward_out, ch, ff);
        end
    endtask

    task automatic test_reset;
        step;
        step;
        vec++;
        if (in_ready !== 1'b0 || fir_go !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || weight_adjust !== '0 || feedforward_out !== '0 || fir_ch !== '0 || out_ch !== '0) begin
            miss++;
            $display("FAIL reset_hold: rdy=%b go=%b ov=%b busy=%b te=%b w=%h ff=%h fc=%0d oc=%0d expected all 0",
                     in_ready, fir_go, out_valid, busy, timeout_err, weight_adjust, feedforward_out, fir_ch, out_ch);
        end
        rst = 0;
        step;
        vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miss++;
            $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic;
        txn(0, 16'h4000, 16'h0000, 16'h4000, 16'h1234, 2, 0, 4'b0001);
    endtask

    task automatic test_saturation;
        txn(1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hAAAA, 0, 0, 4'b0000);
        txn(2, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h5555, 1, 0, 4'b0000);
    endtask

    task automatic test_rounding;
        txn(0, 16'h0001, 16'h0000, 16'h4000, 16'h0001, 0, 0, 4'b1111);
        txn(3, 16'hFFFF, 16'h0000, 16'h4000, 16'hFFFF, 0, 0, 4'b1111);
    endtask

    task automatic test_done_tie;
        txn(1, 16'h1000, 16'hF000, 16'h2000, 16'h0F0F, TIMEOUT, 0, 4'b0000);
    endtask

    task automatic test_drop;
        int ch;
        ch_enable = 4'b1011; in_ch = 2; in_valid = 1;
        step;
        in_valid = 0;
        vec++;
        if (fir_go !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miss++;
            $display("FAIL drop_ch2: fir_go=%b busy=%b in_ready=%b expected 0 0 1", fir_go, busy, in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            ch = $urandom_range(0, NCH - 1);
            ch_enable = 4'($urandom) & ~(4'b1 << ch); in_ch = CHW'(ch); in_valid = 1;
            step;
            in_valid = 0;
            vec++;
            if (fir_go !== 1'b0 || busy !== 1'b0) begin
                miss++;
                $display("FAIL drop_rand: ch=%0d fir_go=%b busy=%b expected 0 0", ch, fir_go, busy);
            end
        end
        txn(3, 16'h0800, 16'h0100, 16'h7000, 16'h3333, 1, 0, 4'b1011);
    endtask

    task automatic test_hold;
        txn(2, 16'h2345, 16'hE000, 16'h6000, 16'h4444, 1, 5, 4'b0000);
    endtask

    task automatic test_timeout;
        txn(1, 16'h4000, 16'h0000, 16'h4000, 16'h7777, 1000, 0, 4'b0000);
        txn(0, 16'h0100, 16'h0000, 16'h4000, 16'h8888, 0, 1, 4'b0000);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            txn($urandom_range(0, NCH - 1), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, TIMEOUT + 3), $urandom_range(0, 3), 4'($urandom));
    endtask

    task automatic test_reset_wait;
        ch_enable = 4'b0010; in_ch = 1; in_valid = 1;
        error_in = 16'h3000; desired_in = 16'h1000; u_in = 16'h5000; feedforward_in = 16'h9999;
        step;
        in_valid = 0;
        step;
        step;
        rst = 1;
        step;
        te_exp = 0;
        vec++;
        if (in_ready !== 1'b0 || fir_go !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || weight_adjust !== '0 || feedforward_out !== '0 || fir_ch !== '0 || out_ch !== '0) begin
            miss++;
            $display("FAIL reset_wait: rdy=%b go=%b ov=%b busy=%b te=%b w=%h ff=%h fc=%0d oc=%0d expected all 0",
                     in_ready, fir_go, out_valid, busy, timeout_err, weight_adjust, feedforward_out, fir_ch, out_ch);
        end
        rst = 0;
        step;
        txn(2, 16'h0400, 16'h0200, 16'h7FFF, 16'h0102, 3, 0, 4'b0000);
        txn(3, 16'h0400, 16'h0200, 16'h7FFF, 16'h0304, TIMEOUT + 1, 0, 4'b0000);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_rounding;
        test_done_tie;
        test_drop;
        test_hold;
        test_timeout;
        test_random;
        test_reset_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
